// File: rtl/axi4_slave_mem.sv
// AXI4 responder backed by a word-addressed memory: one outstanding INCR write
// burst and one outstanding INCR read burst, each handled by its own FSM.
module axi4_slave_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic [1:0]              dbg_wstate_o,
    output logic                    dbg_rstate_o
);
    // Handshakes: a transfer happens on a rising edge where VALID && READY.
    // VALID never depends combinationally on READY; once raised, VALID and
    // its payload stay stable until the transfer completes.

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF    = $clog2(STRB_W);
    // One spare bit so a burst running past the top of the address space
    // keeps counting upward and stays out of range instead of wrapping.
    localparam int IDX_W  = ADDR_WIDTH - OFF + 1;
    localparam int MAW    = $clog2(MEM_DEPTH);
    localparam logic [IDX_W-1:0] DEPTH = IDX_W'(MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    w_state_e         w_state_q, w_state_d;
    logic [IDX_W-1:0] w_idx_q, w_idx_d;
    logic [7:0]       w_len_q, w_len_d;
    logic [7:0]       w_beat_q, w_beat_d;
    logic             w_err_q, w_err_d;

    r_state_e              r_state_q, r_state_d;
    logic [IDX_W-1:0]      r_idx_q, r_idx_d;
    logic [7:0]            r_len_q, r_len_d;
    logic [7:0]            r_beat_q, r_beat_d;
    logic                  r_last_q, r_last_d;
    logic [1:0]            r_resp_q, r_resp_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic [IDX_W-1:0]      r_fetch_idx;
    logic                  r_load;

    logic w_in_range;
    logic w_last_beat;
    logic mem_we;
    logic unused_addr_lsbs;

    assign unused_addr_lsbs = ^{AWADDR[OFF-1:0], ARADDR[OFF-1:0]};
    assign w_in_range  = (w_idx_q < DEPTH);
    assign w_last_beat = (w_beat_q == w_len_q);

    // ---------------- write FSM ----------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_beat_q  <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_beat_q  <= w_beat_d;
            w_err_q   <= w_err_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_beat_d  = w_beat_q;
        w_err_d   = w_err_q;
        case (w_state_q)
            W_IDLE: begin
                if (AWVALID && AWREADY) begin
                    w_state_d = W_DATA;
                    w_idx_d   = {1'b0, AWADDR[ADDR_WIDTH-1:OFF]};
                    w_len_d   = AWLEN;
                    w_beat_d  = '0;
                    w_err_d   = 1'b0;
                end
            end
            W_DATA: begin
                if (WVALID && WREADY) begin
                    w_idx_d  = w_idx_q + IDX_W'(1);
                    w_beat_d = w_beat_q + 8'(1);
                    if (!w_in_range || (WLAST != w_last_beat))
                        w_err_d = 1'b1;
                    // The beat count, not WLAST, closes the burst.
                    if (w_last_beat)
                        w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (BVALID && BREADY)
                    w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        AWREADY      = (w_state_q == W_IDLE);
        WREADY       = (w_state_q == W_DATA);
        BVALID       = (w_state_q == W_RESP);
        BRESP        = (w_state_q == W_RESP && w_err_q) ? 2'b10 : 2'b00;
        dbg_wstate_o = w_state_q;
    end

    // Index is truncated to MAW bits; MEM_DEPTH is expected to be a power of two.
    assign mem_we = WVALID && WREADY && w_in_range && !ARESET;

    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (WSTRB[b])
                    mem_q[w_idx_q[MAW-1:0]][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
        end
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            r_last_q  <= 1'b0;
            r_resp_q  <= 2'b00;
            r_data_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_beat_q  <= r_beat_d;
            r_last_q  <= r_last_d;
            r_resp_q  <= r_resp_d;
            r_data_q  <= r_data_d;
        end
    end

    // Memory is sampled before this edge's write lands, so a same-cycle
    // read of a word being written returns the old contents.
    always_comb begin
        r_state_d   = r_state_q;
        r_idx_d     = r_idx_q;
        r_len_d     = r_len_q;
        r_beat_d    = r_beat_q;
        r_last_d    = r_last_q;
        r_resp_d    = r_resp_q;
        r_data_d    = r_data_q;
        r_fetch_idx = r_idx_q + IDX_W'(1);
        r_load      = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (ARVALID && ARREADY) begin
                    r_state_d   = R_DATA;
                    r_fetch_idx = {1'b0, ARADDR[ADDR_WIDTH-1:OFF]};
                    r_idx_d     = r_fetch_idx;
                    r_len_d     = ARLEN;
                    r_beat_d    = '0;
                    r_last_d    = (ARLEN == 8'd0);
                    r_load      = 1'b1;
                end
            end
            R_DATA: begin
                if (RVALID && RREADY) begin
                    if (r_last_q) begin
                        r_state_d = R_IDLE;
                        r_last_d  = 1'b0;
                    end else begin
                        r_idx_d  = r_fetch_idx;
                        r_beat_d = r_beat_q + 8'(1);
                        r_last_d = (r_beat_d == r_len_q);
                        r_load   = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (r_load) begin
            if (r_fetch_idx < DEPTH) begin
                r_data_d = mem_q[r_fetch_idx[MAW-1:0]];
                r_resp_d = 2'b00;
            end else begin
                r_data_d = '0;
                r_resp_d = 2'b10;
            end
        end
    end

    always_comb begin
        ARREADY      = (r_state_q == R_IDLE);
        RVALID       = (r_state_q == R_DATA);
        RLAST        = r_last_q;
        RRESP        = r_resp_q;
        RDATA        = r_data_q;
        dbg_rstate_o = r_state_q;
    end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed bench for axi4_slave_mem: bursts, strobes, stalls, out-of-range
// accesses, WLAST errors, same-cycle read/write and mid-burst reset.
module tb_axi4_slave_mem;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [15:0] AWADDR;
    logic [7:0]  AWLEN;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [15:0] ARADDR;
    logic [7:0]  ARLEN;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic [1:0]  dbg_wstate;
    logic        dbg_rstate;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] wdat_q[$];

    localparam int TMO = 20;

    axi4_slave_mem dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .dbg_wstate_o(dbg_wstate), .dbg_rstate_o(dbg_rstate)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic aw_send(input logic [15:0] addr, input logic [7:0] len);
        int n = 0;
        AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
        while (!AWREADY && n < TMO) begin tick(); n++; end
        if (n >= TMO) chk("aw_timeout", 1, 0);
        tick();
        AWVALID = 1'b0;
    endtask

    task automatic ar_send(input logic [15:0] addr, input logic [7:0] len);
        int n = 0;
        ARADDR = addr; ARLEN = len; ARVALID = 1'b1;
        while (!ARREADY && n < TMO) begin tick(); n++; end
        if (n >= TMO) chk("ar_timeout", 1, 0);
        tick();
        ARVALID = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        int n = 0;
        WDATA = d; WSTRB = s; WLAST = l; WVALID = 1'b1;
        while (!WREADY && n < TMO) begin tick(); n++; end
        if (n >= TMO) chk("w_timeout", 1, 0);
        tick();
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic b_recv(input logic [1:0] resp);
        int n = 0;
        while (!BVALID && n < TMO) begin tick(); n++; end
        if (n >= TMO) chk("b_timeout", 1, 0);
        chk("bresp", BRESP, resp);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        chk("bvalid_clear", BVALID, 0);
        chk("awready_back", AWREADY, 1);
    endtask

    // bad_beat inverts WLAST on that beat (-1 for none); data comes from wdat_q.
    task automatic write_burst(input logic [15:0] addr, input logic [7:0] len,
                               input logic [3:0] strb, input int bad_beat,
                               input logic [1:0] resp);
        aw_send(addr, len);
        for (int i = 0; i <= int'(len); i++)
            w_beat(wdat_q.pop_front(), strb, (i == int'(len)) ^ (i == bad_beat));
        chk("bvalid_after_last", BVALID, 1);
        chk("wready_after_last", WREADY, 0);
        b_recv(resp);
    endtask

    task automatic read_burst(input logic [15:0] addr, input logic [7:0] len,
                              input logic [1:0] resp, input int stall_beat,
                              input int stall_cyc);
        logic [31:0] d;
        logic        l;
        ar_send(addr, len);
        for (int i = 0; i <= int'(len); i++) begin
            chk("rvalid", RVALID, 1);
            if (i == stall_beat) begin
                d = RDATA; l = RLAST;
                repeat (stall_cyc) begin
                    tick();
                    chk("stall_rvalid", RVALID, 1);
                    chk("stall_rdata", RDATA, d);
                    chk("stall_rlast", RLAST, l);
                end
            end
            chk("rdata", RDATA, exp_q.pop_front());
            chk("rresp", RRESP, resp);
            chk("rlast", RLAST, i == int'(len));
            RREADY = 1'b1;
            tick();
            RREADY = 1'b0;
        end
        chk("rvalid_end", RVALID, 0);
        chk("rlast_end", RLAST, 0);
    endtask

    task automatic write_word(input logic [15:0] addr, input logic [31:0] d);
        wdat_q.push_back(d);
        write_burst(addr, 8'd0, 4'hF, -1, 2'b00);
    endtask

    task automatic read_word(input logic [15:0] addr, input logic [31:0] d);
        exp_q.push_back(d);
        read_burst(addr, 8'd0, 2'b00, -1, 0);
    endtask

    initial begin
        ARESET = 1'b1;
        AWADDR = '0; AWLEN = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b0;

        // 1: reset
        repeat (2) tick();
        ARESET = 1'b0;
        tick();
        chk("rst_awready", AWREADY, 1);
        chk("rst_arready", ARREADY, 1);
        chk("rst_wready", WREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rlast", RLAST, 0);
        chk("rst_bresp", BRESP, 0);
        chk("rst_rresp", RRESP, 0);
        chk("rst_rdata", RDATA, 0);

        // 2: 4-beat write and read-back
        for (int i = 0; i < 4; i++) wdat_q.push_back(32'hA0 + i);
        write_burst(16'h0010, 8'd3, 4'hF, -1, 2'b00);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + i);
        read_burst(16'h0010, 8'd3, 2'b00, -1, 0);

        // 3: partial strobe; single-beat read has RLAST on beat 0
        write_word(16'h0020, 32'h12345678);
        wdat_q.push_back(32'hFFFFFFFF);
        write_burst(16'h0020, 8'd0, 4'b0011, -1, 2'b00);
        read_word(16'h0020, 32'h1234FFFF);

        // 4: stall at beat 1 for 3 cycles
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + i);
        read_burst(16'h0010, 8'd3, 2'b00, 1, 3);

        // 5: out-of-range read and write; aliased words must stay untouched
        write_word(16'h0000, 32'h11111111);
        write_word(16'h0FFC, 32'h22222222);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        read_burst(16'hFFFC, 8'd1, 2'b10, -1, 0);
        wdat_q.push_back(32'hDEADBEEF); wdat_q.push_back(32'hCAFEF00D);
        write_burst(16'hFFFC, 8'd1, 4'hF, -1, 2'b10);
        read_word(16'h0000, 32'h11111111);
        read_word(16'h0FFC, 32'h22222222);

        // 6: early WLAST flags SLVERR but the burst still completes by count
        wdat_q.push_back(32'hB0); wdat_q.push_back(32'hB1);
        write_burst(16'h0030, 8'd1, 4'hF, 0, 2'b10);
        exp_q.push_back(32'hB0); exp_q.push_back(32'hB1);
        read_burst(16'h0030, 8'd1, 2'b00, -1, 0);

        // 7a: AW and AR accepted on the same edge
        write_word(16'h0060, 32'hC0C0C0C0);
        AWADDR = 16'h0060; AWLEN = 8'd0; AWVALID = 1'b1;
        ARADDR = 16'h0060; ARLEN = 8'd0; ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0; ARVALID = 1'b0;
        chk("dual_wready", WREADY, 1);
        chk("dual_rvalid", RVALID, 1);
        chk("dual_rdata", RDATA, 32'hC0C0C0C0);
        chk("dual_rlast", RLAST, 1);
        w_beat(32'h60606060, 4'hF, 1'b1);
        chk("dual_bvalid", BVALID, 1);
        b_recv(2'b00);
        RREADY = 1'b1; tick(); RREADY = 1'b0;
        chk("dual_rvalid_end", RVALID, 0);
        read_word(16'h0060, 32'h60606060);

        // 7b: AR handshake on the same edge as a write beat to that word
        write_word(16'h0070, 32'hD0D0D0D0);
        aw_send(16'h0070, 8'd0);
        WDATA = 32'h70707070; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
        ARADDR = 16'h0070; ARLEN = 8'd0; ARVALID = 1'b1;
        tick();
        WVALID = 1'b0; WLAST = 1'b0; ARVALID = 1'b0;
        chk("rw_same_rdata_old", RDATA, 32'hD0D0D0D0);
        chk("rw_same_bvalid", BVALID, 1);
        RREADY = 1'b1; tick(); RREADY = 1'b0;
        b_recv(2'b00);
        read_word(16'h0070, 32'h70707070);

        // 8: reset during beat 2 of a 4-beat write
        aw_send(16'h0040, 8'd3);
        w_beat(32'hE0, 4'hF, 1'b0);
        w_beat(32'hE1, 4'hF, 1'b0);
        WDATA = 32'hE2; WSTRB = 4'hF; WVALID = 1'b1; ARESET = 1'b1;
        tick();
        WVALID = 1'b0; ARESET = 1'b0;
        chk("mid_rst_bvalid", BVALID, 0);
        chk("mid_rst_awready", AWREADY, 1);
        chk("mid_rst_wready", WREADY, 0);
        exp_q.push_back(32'hE0); exp_q.push_back(32'hE1);
        read_burst(16'h0040, 8'd1, 2'b00, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
